// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: classifies the EX/MEM slot, runs the data-memory
// handshake, stalls upstream while a load/store is in flight and drives MEM/WB.
module mem_stage_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  ex_opcode,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2_out,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        stall,
  output logic        misaligned,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic        is_load, is_store, is_link, is_alu, is_mem;
  logic        is_half, is_word, mis_c, mem_go;
  logic [1:0]  off;
  logic        rd_req_d, wr_req_d;
  logic        wb_we_d;
  logic [31:0] wb_data_d;
  logic [31:0] ld_data_p1;

  // Shift the addressed lane down and extend according to funct3.
  function automatic logic [31:0] ld_extend(input logic [31:0] raw,
                                            input logic [1:0]  lane,
                                            input logic [2:0]  f3);
    logic [31:0] sh;
    sh = raw >> {lane, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  always_comb begin
    is_load  = (ex_opcode == OP_LOAD);
    is_store = (ex_opcode == OP_STORE);
    is_link  = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
    is_alu   = (ex_opcode == OP_IMM) || (ex_opcode == OP_REG) ||
               (ex_opcode == OP_LUI) || (ex_opcode == OP_AUIPC);
    is_mem   = is_load || is_store;
    off      = ex_alu_out[1:0];
    is_half  = (ex_funct3[1:0] == 2'b01);
    is_word  = ex_funct3[1];
    mis_c    = is_mem && ((is_half && off[0]) || (is_word && (off != 2'b00)));
    mem_go   = is_mem && !mis_c;
  end

  assign stall        = mem_go && (state != DONE);
  assign dmem_address = {ex_alu_out[31:2], 2'b00};
  assign dmem_wdata   = ex_rs2_out << {off, 3'b000};

  always_comb begin
    dmem_mbe = 4'b0001 << off;
    if (is_word)      dmem_mbe = 4'b1111;
    else if (is_half) dmem_mbe = 4'b0011 << off;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mem_go) state_nxt = BUSY;
      BUSY:    if (dmem_resp) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Requests are registered, so they are high exactly while in BUSY.
    rd_req_d = (state_nxt == BUSY) && is_load;
    wr_req_d = (state_nxt == BUSY) && is_store;
  end

  always_comb begin
    wb_we_d = (is_load || is_link || is_alu) && (ex_rd != 5'd0) && !mis_c;
    if (is_load)      wb_data_d = ld_data_p1;
    else if (is_link) wb_data_d = ex_pc + 32'd4;
    else              wb_data_d = ex_alu_out;
  end

  // MEM -> WB boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      dmem_read   <= 1'b0;
      dmem_write  <= 1'b0;
      misaligned  <= 1'b0;
      ld_data_p1  <= 32'd0;
      wb_regwrite <= 1'b0;
      wb_rd       <= 5'd0;
      wb_data     <= 32'd0;
    end else begin
      state      <= state_nxt;
      dmem_read  <= rd_req_d;
      dmem_write <= wr_req_d;
      misaligned <= mis_c;
      if ((state == BUSY) && dmem_resp && is_load)
        ld_data_p1 <= ld_extend(dmem_rdata, off, ex_funct3);
      if (!stall) begin
        wb_regwrite <= wb_we_d;
        wb_rd       <= ex_rd;
        wb_data     <= wb_data_d;
      end else begin
        wb_regwrite <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl with a transaction-level model of the MEM/WB
// and memory-request behaviour, checked every cycle, plus hand-computed pins.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [31:0] ex_pc, ex_alu_out, ex_rs2_out;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        stall, misaligned, wb_regwrite;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk(clk), .rst(rst),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .ex_alu_out(ex_alu_out), .ex_rs2_out(ex_rs2_out),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe), .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp), .stall(stall), .misaligned(misaligned),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  int total = 0;
  int bad   = 0;

  // model state
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_rd, exp_wr;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_mbe;
  logic        m_wb_we, m_mis;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data, m_ld;

  int          stall_cnt, mis_cnt, req_cnt;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_mbe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f_ld(input logic [31:0] raw, input logic [2:0] f3, input int off);
    longint v;
    v = longint'(raw >> (8 * off));
    case (f3)
      3'd0: begin v = v % 256;   if (v >= 128)   v -= 256;   end
      3'd1: begin v = v % 65536; if (v >= 32768) v -= 65536; end
      3'd4: v = v % 256;
      3'd5: v = v % 65536;
      default: ;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [3:0] f_mbe(input logic [2:0] f3, input int off);
    int size;
    size = int'(f3) % 4;
    if (size == 0) return 4'(1 << off);
    if (size == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  // compare process
  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (misaligned) mis_cnt++;
    if (dmem_read || dmem_write) begin
      req_cnt++;
      last_addr  = dmem_address;
      last_mbe   = dmem_mbe;
      last_wdata = dmem_wdata;
    end
    if (chk_en) begin
      chk("stall", stall, exp_stall);
      chk("dmem_read", dmem_read, exp_rd);
      chk("dmem_write", dmem_write, exp_wr);
      chk("misaligned", misaligned, m_mis);
      chk("wb_regwrite", wb_regwrite, m_wb_we);
      chk("wb_rd", wb_rd, m_wb_rd);
      chk("wb_data", wb_data, m_wb_data);
      if (exp_rd || exp_wr) begin
        chk("dmem_address", dmem_address, exp_addr);
        chk("dmem_mbe", dmem_mbe, exp_mbe);
        chk("dmem_wdata", dmem_wdata, exp_wdata);
      end
    end
  end

  task automatic set_slot(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2);
    ex_opcode = opc; ex_funct3 = f3; ex_rd = rd;
    ex_pc = pc; ex_alu_out = alu; ex_rs2_out = rs2;
  endtask

  // Presents one slot and walks it through to its MEM/WB result.
  // Called and returning 1 time unit after a rising edge.
  task automatic op(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                    input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                    input logic [31:0] rdata, input int nbusy, input logic stray);
    logic ld, st, link, aluop, mis, go;
    int off, size;
    ld    = (opc == 7'b0000011);
    st    = (opc == 7'b0100011);
    link  = (opc == 7'b1101111) || (opc == 7'b1100111);
    aluop = (opc == 7'b0010011) || (opc == 7'b0110011) ||
            (opc == 7'b0110111) || (opc == 7'b0010111);
    off   = int'(alu % 4);
    size  = int'(f3) % 4;
    mis   = (ld || st) && ((size == 1 && off % 2 == 1) || (size >= 2 && off != 0));
    go    = (ld || st) && !mis;
    exp_addr  = alu - 32'(off);
    exp_mbe   = f_mbe(f3, off);
    exp_wdata = rs2 << (8 * off);
    set_slot(opc, f3, rd, pc, alu, rs2);
    if (!go) begin
      exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
      dmem_resp = stray; dmem_rdata = rdata;
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      m_wb_rd   = rd;
      m_wb_data = ld ? m_ld : (link ? pc + 32'd4 : alu);
      m_wb_we   = (ld || link || aluop) && (rd != 5'd0) && !mis;
      m_mis     = mis;
    end else begin
      exp_stall = 1'b1; exp_rd = 1'b0; exp_wr = 1'b0;
      @(posedge clk); #1;
      m_wb_we = 1'b0; m_mis = 1'b0;
      for (int i = 1; i <= nbusy; i++) begin
        exp_rd = ld; exp_wr = st;
        if (i == nbusy) begin dmem_resp = 1'b1; dmem_rdata = rdata; end
        @(posedge clk); #1;
        dmem_resp = 1'b0;
      end
      if (ld) m_ld = f_ld(rdata, f3, off);
      exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
      @(posedge clk); #1;
      m_wb_rd   = rd;
      m_wb_data = ld ? m_ld : alu;
      m_wb_we   = ld && (rd != 5'd0);
    end
  endtask

  task automatic bubble();
    op(7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    set_slot(7'd0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    dmem_rdata = 32'd0; dmem_resp = 1'b0;
    exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
    exp_addr = 32'd0; exp_mbe = 4'd0; exp_wdata = 32'd0;
    m_wb_we = 1'b0; m_wb_rd = 5'd0; m_wb_data = 32'd0; m_mis = 1'b0; m_ld = 32'd0;
    stall_cnt = 0; mis_cnt = 0; req_cnt = 0;
    last_addr = 32'd0; last_mbe = 4'd0; last_wdata = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dmem_read", dmem_read, 1'b0);
    chk("rst_dmem_write", dmem_write, 1'b0);
    chk("rst_misaligned", misaligned, 1'b0);
    chk("rst_wb_regwrite", wb_regwrite, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // addi x5 -> 0x10
    stall_cnt = 0;
    op(7'b0010011, 3'd0, 5'd5, 32'h0, 32'h10, 32'h0, 32'h0, 0, 1'b0);
    chk("alu_wb_regwrite", wb_regwrite, 1'b1);
    chk("alu_wb_rd", wb_rd, 5'd5);
    chk("alu_wb_data", wb_data, 32'h10);
    chk("alu_stall_cnt", stall_cnt, 0);

    // lb at 0x103, three BUSY cycles
    stall_cnt = 0;
    op(7'b0000011, 3'd0, 5'd6, 32'h0, 32'h103, 32'h0, 32'h80FFFFFF, 3, 1'b0);
    chk("lb_mbe", last_mbe, 4'b1000);
    chk("lb_stall_cnt", stall_cnt, 4);
    chk("lb_wb_data", wb_data, 32'hFFFFFF80);
    chk("lb_wb_regwrite", wb_regwrite, 1'b1);

    // sh at 0x202
    op(7'b0100011, 3'd1, 5'd9, 32'h0, 32'h202, 32'h0000BEEF, 32'h0, 2, 1'b0);
    chk("sh_addr", last_addr, 32'h200);
    chk("sh_mbe", last_mbe, 4'b1100);
    chk("sh_wdata", last_wdata, 32'hBEEF0000);
    chk("sh_wb_regwrite", wb_regwrite, 1'b0);

    // misaligned lw at 0x101
    stall_cnt = 0; mis_cnt = 0; req_cnt = 0;
    op(7'b0000011, 3'd2, 5'd8, 32'h0, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    chk("mis_wb_regwrite", wb_regwrite, 1'b0);
    bubble();
    chk("mis_pulses", mis_cnt, 1);
    chk("mis_stall_cnt", stall_cnt, 0);
    chk("mis_req_cnt", req_cnt, 0);

    // zero-wait lbu at 0x4
    stall_cnt = 0;
    op(7'b0000011, 3'd4, 5'd10, 32'h0, 32'h4, 32'h0, 32'h000000F0, 1, 1'b0);
    chk("lbu_wb_data", wb_data, 32'hF0);
    chk("lbu_stall_cnt", stall_cnt, 2);

    op(7'b1101111, 3'd0, 5'd1, 32'h400, 32'h888, 32'h0, 32'h0, 0, 1'b0);
    chk("jal_wb_data", wb_data, 32'h404);
    op(7'b0110111, 3'd0, 5'd0, 32'h0, 32'hABC00000, 32'h0, 32'h0, 0, 1'b0);
    op(7'b0000011, 3'd1, 5'd11, 32'h0, 32'h2, 32'h0, 32'h80010000, 2, 1'b0);
    chk("lh_wb_data", wb_data, 32'hFFFF8001);
    op(7'b0100011, 3'd2, 5'd0, 32'h0, 32'h10, 32'h11223344, 32'h0, 1, 1'b0);
    op(7'b0000011, 3'd2, 5'd12, 32'h0, 32'h10, 32'h0, 32'hCAFEBABE, 1, 1'b0);
    op(7'b0100011, 3'd0, 5'd0, 32'h0, 32'h7, 32'h000000A5, 32'h0, 2, 1'b0);
    chk("sb_mbe", last_mbe, 4'b1000);
    chk("sb_wdata", last_wdata, 32'hA5000000);
    // stray response outside BUSY must not disturb the captured load data
    op(7'b0110011, 3'd0, 5'd13, 32'h0, 32'h55, 32'h0, 32'hDEADDEAD, 0, 1'b1);
    op(7'b0000011, 3'd1, 5'd14, 32'h0, 32'h3, 32'h0, 32'h0, 0, 1'b0);
    op(7'b0000000, 3'd0, 5'd3, 32'h0, 32'h77, 32'h0, 32'h0, 0, 1'b0);

    // reset during the second BUSY cycle of an lw
    chk_en = 1'b0;
    set_slot(7'b0000011, 3'd2, 5'd7, 32'h0, 32'h100, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstbusy_read_before", dmem_read, 1'b1);
    #2 rst = 1'b0;
    #1 chk("rstbusy_read_async", dmem_read, 1'b0);
    set_slot(7'd0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    chk("rstbusy_wb_regwrite", wb_regwrite, 1'b0);
    chk("rstbusy_read_after", dmem_read, 1'b0);
    chk("rstbusy_stall", stall, 1'b0);
    m_wb_we = 1'b0; m_wb_rd = 5'd0; m_wb_data = 32'd0; m_mis = 1'b0; m_ld = 32'd0;
    exp_stall = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
    chk_en = 1'b1;
    bubble();
    op(7'b0000011, 3'd2, 5'd4, 32'h0, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    chk("rstbusy_ld_cleared", wb_data, 32'd0);
    bubble();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The module SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-002 The module SHALL have the following ports, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- ex_opcode  in  7  EX/MEM opcode; a flushed slot reads 7'd0 and is a bubble.
- ex_funct3  in  3  EX/MEM funct3.
- ex_rd  in  5  EX/MEM destination register.
- ex_pc  in  32  EX/MEM pc.
- ex_alu_out  in  32  EX/MEM ALU result, also the effective address.
- ex_rs2_out  in  32  EX/MEM store source.
- dmem_read  out  1  data-memory read request.
- dmem_write  out  1  data-memory write request.
- dmem_address  out  32  word-aligned address, {ex_alu_out[31:2],2'b00}.
- dmem_wdata  out  32  lane-shifted store data.
- dmem_mbe  out  4  byte enables.
- dmem_rdata  in  32  read data, valid with dmem_resp.
- dmem_resp  in  1  single-cycle completion pulse.
- stall  out  1  high = hold all upstream pipeline registers (their load = ~stall).
- misaligned  out  1  registered one-cycle pulse on a misaligned access.
- wb_regwrite  out  1  MEM/WB write enable.
- wb_rd  out  5  MEM/WB destination.
- wb_data  out  32  MEM/WB write data.

Function
REQ-003 The block SHALL classify the slot as: load (0000011), store (0100011), jal/jalr (1101111/1100111), reg-writing ALU (0010011, 0110011, 0110111, 0010111), or other/bubble.
REQ-004 The state machine SHALL have states IDLE, BUSY and DONE.
REQ-005 In IDLE, an aligned load or store SHALL move the machine to BUSY on the next edge; all other slots SHALL stay in IDLE.
REQ-006 In BUSY, dmem_read or dmem_write SHALL be held high, with address, wdata and mbe stable, until dmem_resp; on dmem_resp the machine SHALL enter DONE.
REQ-007 In DONE, the requests SHALL be low and the machine SHALL return to IDLE on the next edge.
REQ-008 stall SHALL be combinational and equal (aligned load/store in slot) AND (state != DONE).
REQ-009 For a memory op, stall SHALL be high for the IDLE cycle plus every BUSY cycle, and low in DONE, so that the pipeline advances exactly once per op.
REQ-010 dmem_read and dmem_write SHALL be registered outputs, high only in BUSY, and never high together.
REQ-011 Byte enables for lb/lbu/sb SHALL be 4'b0001<<off, where off = ex_alu_out[1:0].
REQ-012 Byte enables for lh/lhu/sh SHALL be 4'b0011<<off.
REQ-013 Byte enables for lw/sw SHALL be 4'b1111.
REQ-014 dmem_wdata SHALL be ex_rs2_out<<(8*off).
REQ-015 Misalignment SHALL be defined as: halfword with off[0]=1, or word with off!=0.
REQ-016 A misaligned op SHALL issue no request and assert no stall.
REQ-017 A misaligned op SHALL pulse misaligned for one cycle and produce wb_regwrite=0.
REQ-018 Load data SHALL be dmem_rdata>>(8*off), sign-extended for lb/lh and zero-extended for lbu/lhu.
REQ-019 Load data SHALL be captured into an internal register on dmem_resp.
REQ-020 The MEM/WB outputs SHALL be loaded on every edge where stall=0.
- wb_rd = ex_rd.
- wb_data = captured load data for a load, ex_pc+4 for jal/jalr, ex_alu_out otherwise.
- wb_regwrite = (load or jal/jalr or reg-writing ALU) AND ex_rd!=0 AND not misaligned.
REQ-021 While stall=1, the MEM/WB outputs SHALL be loaded with a bubble: wb_regwrite=0, with wb_rd and wb_data holding their values.
REQ-022 A non-memory op SHALL reach the MEM/WB outputs one edge after it is in the slot (latency 1).
REQ-023 A memory op SHALL reach the MEM/WB outputs on the edge leaving DONE (latency = 2 + BUSY cycles).
REQ-024 A dmem_resp arriving outside BUSY SHALL be ignored.
REQ-025 A dmem_resp arriving on the first BUSY cycle SHALL be legal (zero-wait memory).
REQ-026 Back-to-back memory ops SHALL each pass through DONE then IDLE, with no request overlap.
REQ-027 A bubble (opcode 0) SHALL never stall, request memory, or write back.

Reset
REQ-028 When rst=0, the machine SHALL go to IDLE asynchronously, including mid-BUSY, and the registered outputs SHALL take these reset values:
- dmem_read=0, dmem_write=0.
- misaligned=0.
- wb_regwrite=0, wb_rd=0, wb_data=0.
- captured load data=0.
REQ-029 After release of rst, the first request SHALL require a fresh slot evaluation in IDLE.

Verification
REQ-030 The bench SHALL cover ALU op: opcode 0010011, rd=5, alu_out=0x10 -> next edge wb_regwrite=1, wb_rd=5, wb_data=0x10, stall never 1.
REQ-031 The bench SHALL cover lb with sign extension: addr 0x103, rdata 0x80FFFFFF, resp after 3 BUSY cycles -> mbe=1000, stall high 4 cycles, wb_data=0xFFFFFF80.
REQ-032 The bench SHALL cover sh: addr 0x202, rs2=0x0000BEEF -> dmem_write=1, address 0x200, mbe=1100, wdata=0xBEEF0000, wb_regwrite=0.
REQ-033 The bench SHALL cover a misaligned lw: addr 0x101 -> no request, misaligned pulses once, wb_regwrite=0, stall stays 0.
REQ-034 The bench SHALL cover reset mid-BUSY: rst low during the 2nd BUSY cycle of lw -> dmem_read=0 immediately; a resp after release is ignored and wb_regwrite=0.
REQ-035 The bench SHALL cover a zero-wait lbu: resp on the first BUSY cycle at addr 0x4, rdata 0x000000F0 -> wb_data=0xF0, total stall 2 cycles.
